// File: rtl/coax_pkg.sv
// Shared definitions for the coax transmit path: frame state encoding and field lengths.
package coax_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LQ,
    CV,
    SYNC,
    DATA,
    PARITY,
    END0,
    END1
  } coax_state_e;

  localparam int unsigned LQ_BITS     = 5;
  localparam int unsigned DATA_BITS   = 10;
  localparam int unsigned CV_BITS     = 2;
  localparam int unsigned BIT_CNT_MAX = (LQ_BITS > DATA_BITS) ? LQ_BITS : DATA_BITS;
  localparam int unsigned BIT_CNT_W   = $clog2(BIT_CNT_MAX);

  // Even parity over data plus parity bit.
  function automatic logic word_parity(input logic [DATA_BITS-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/coax_tx_bit_timer.sv
// Bit-period timer: marks the first half of each bit time, the first clock and the last clock.
module coax_tx_bit_timer #(
  parameter int unsigned CLOCKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  output logic o_first_half,
  output logic o_bit_start,
  output logic o_end_strobe
);

  localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_BIT / 2);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (o_end_strobe) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_first_half = (r_cnt < CNT_HALF);
  assign o_bit_start  = (r_cnt == '0);
  assign o_end_strobe = (r_cnt == CNT_LAST);

endmodule

// File: rtl/coax_tx_sequencer.sv
// Coax transmit framer: quiesce, code violation, sync/data/parity per word, ending sequence.
// Optional COAX_TX_PREEMPH_EN adds tx_delay, a copy of tx delayed by CLOCKS_PER_BIT/4 clocks.
module coax_tx_sequencer
  import coax_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_active,
  output logic       tx
`ifdef COAX_TX_PREEMPH_EN
  ,
  output logic       tx_delay
`endif
);

  localparam logic [BIT_CNT_W-1:0] LQ_LAST   = BIT_CNT_W'(LQ_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] CV_LAST   = BIT_CNT_W'(CV_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);

  coax_state_e          r_state, w_state_next;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [9:0]           r_hold, r_shift;
  logic                 r_hold_full, r_parity;
  logic                 r_tx, r_active;
  logic                 w_tx_next, w_active_next;
  logic                 w_hs, w_unload, w_timer_rst;
  logic                 w_first_half, w_bit_start, w_end_strobe;

  // Timer is parked in IDLE so the first quiesce bit starts on a clean boundary.
  assign w_timer_rst = reset | (r_state == IDLE);

  coax_tx_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clk         (clk),
    .reset       (w_timer_rst),
    .o_first_half(w_first_half),
    .o_bit_start (w_bit_start),
    .o_end_strobe(w_end_strobe)
  );

  assign w_hs     = tx_valid & ~r_hold_full;
  assign w_unload = (r_state == SYNC) & w_bit_start;
  assign tx_ready = ~r_hold_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_tx_next     = 1'b0;
    w_active_next = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_active_next = 1'b0;
        if (r_hold_full || w_hs) w_state_next = LQ;
      end
      LQ: begin
        w_tx_next = ~w_first_half;
        if (w_end_strobe && (r_bit_cnt == LQ_LAST)) w_state_next = CV;
      end
      CV: begin
        // Flat low then flat high: no mid-bit transition marks the frame start.
        w_tx_next = (r_bit_cnt != '0);
        if (w_end_strobe && (r_bit_cnt == CV_LAST)) w_state_next = SYNC;
      end
      SYNC: begin
        w_tx_next = ~w_first_half;
        if (w_end_strobe) w_state_next = DATA;
      end
      DATA: begin
        w_tx_next = r_shift[9] ^ w_first_half;
        if (w_end_strobe && (r_bit_cnt == DATA_LAST)) w_state_next = PARITY;
      end
      PARITY: begin
        w_tx_next = r_parity ^ w_first_half;
        if (w_end_strobe) w_state_next = r_hold_full ? SYNC : END0;
      end
      END0: begin
        w_tx_next = w_first_half;
        if (w_end_strobe) w_state_next = END1;
      end
      END1: begin
        w_tx_next = 1'b1;
        if (w_end_strobe) w_state_next = IDLE;
      end
      default: begin
        w_active_next = 1'b0;
        w_state_next  = IDLE;
      end
    endcase
  end

  // Every advance lands on an end strobe, so any state change restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= '0;
    end else if (w_end_strobe) begin
      r_bit_cnt <= (w_state_next != r_state) ? '0 : r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
    end else begin
      if (w_hs) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_unload) begin
        r_hold_full <= 1'b0;
      end
      if (w_unload) begin
        r_shift  <= r_hold;
        r_parity <= word_parity(r_hold);
      end else if ((r_state == DATA) && w_end_strobe) begin
        r_shift <= {r_shift[8:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx     <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_tx     <= w_tx_next;
      r_active <= w_active_next;
    end
  end

  assign tx        = r_tx;
  assign tx_active = r_active;

`ifdef COAX_TX_PREEMPH_EN
  localparam int unsigned DLY = CLOCKS_PER_BIT / 4;

  logic [DLY-1:0] r_dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dly <= '0;
    end else begin
      r_dly <= (r_dly << 1) | DLY'(r_tx);
    end
  end

  assign tx_delay = r_dly[DLY-1];
`endif

endmodule

// File: tb/tb_coax_tx_sequencer.sv
// Bench for coax_tx_sequencer: waveform-queue reference model plus directed frame scenarios.
module tb_coax_tx_sequencer;

  localparam int CPB = 8;
  localparam int DLY = CPB / 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_active, tx;
`ifdef COAX_TX_PREEMPH_EN
  logic       tx_delay;
`endif

  coax_tx_sequencer #(
    .CLOCKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_active(tx_active),
    .tx       (tx)
`ifdef COAX_TX_PREEMPH_EN
    ,
    .tx_delay (tx_delay)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: each frame is a queue of per-clock line levels built from bit rules.
  typedef struct packed {
    logic lvl;
    logic act;
    logic unl;
    logic dec;
    logic fin;
  } samp_t;

  samp_t      line_q[$];
  samp_t      m_cur;
  logic       m_full;
  logic [9:0] m_hold;
  logic       e_tx, e_act, e_rdy;
  logic [DLY-1:0] e_hist;

  function automatic samp_t mk(input logic lvl, input logic act, input logic unl,
                               input logic dec, input logic fin);
    samp_t s;
    s.lvl = lvl;
    s.act = act;
    s.unl = unl;
    s.dec = dec;
    s.fin = fin;
    return s;
  endfunction

  task automatic push_bit(input logic b, input logic first_unl, input logic last_dec);
    for (int i = 0; i < CPB; i++)
      line_q.push_back(mk((i < CPB / 2) ? ~b : b, 1'b1, first_unl && (i == 0),
                          last_dec && (i == CPB - 1), 1'b0));
  endtask

  task automatic push_level(input logic v, input logic last_fin);
    for (int i = 0; i < CPB; i++)
      line_q.push_back(mk(v, 1'b1, 1'b0, 1'b0, last_fin && (i == CPB - 1)));
  endtask

  task automatic push_word(input logic [9:0] w);
    push_bit(1'b1, 1'b1, 1'b0);
    for (int k = 9; k >= 0; k--) push_bit(w[k], 1'b0, 1'b0);
    push_bit(^w, 1'b0, 1'b1);
  endtask

  task automatic model_reset();
    line_q.delete();
    m_cur  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_full = 1'b0;
    m_hold = '0;
    e_tx   = 1'b0;
    e_act  = 1'b0;
    e_rdy  = 1'b1;
    e_hist = '0;
  endtask

  task automatic model_step();
    logic old_full, hs;
    old_full = m_full;
    hs       = tx_valid && e_rdy;
    e_hist   = (e_hist << 1) | DLY'(e_tx);
    e_tx     = m_cur.lvl;
    e_act    = m_cur.act;
    if (hs) begin
      m_hold = tx_data;
      m_full = 1'b1;
    end else if (m_cur.unl) begin
      m_full = 1'b0;
    end
    if (m_cur.dec) begin
      if (old_full) begin
        push_word(m_hold);
      end else begin
        push_bit(1'b0, 1'b0, 1'b0);
        push_level(1'b1, 1'b1);
      end
    end
    if (line_q.size() > 0) begin
      m_cur = line_q.pop_front();
    end else if (m_cur.fin || !m_full) begin
      m_cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      for (int b = 0; b < 5; b++) push_bit(1'b1, 1'b0, 1'b0);
      push_level(1'b0, 1'b0);
      push_level(1'b1, 1'b0);
      push_word(m_hold);
      m_cur = line_q.pop_front();
    end
    e_rdy = !m_full;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      check("line_outputs", 64'({tx, tx_active, tx_ready}), 64'({e_tx, e_act, e_rdy}));
`ifdef COAX_TX_PREEMPH_EN
      check("tx_delay", 64'(tx_delay), 64'(e_hist[DLY-1]));
`endif
    end
  end

  // Frame monitor: active-run length, preceding idle gap, and second-half bit samples.
  int          run_len[$];
  int          run_gap[$];
  int          run_nbits[$];
  logic [63:0] run_bits[$];
  int          cur_len = 0, cur_gap = 0, start_gap = 0, cur_nbits = 0;
  logic [63:0] cur_bits = '0;
  int          hs_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      cur_len   = 0;
      cur_gap   = 0;
      cur_nbits = 0;
      cur_bits  = '0;
    end else if (tx_active) begin
      if (cur_len == 0) start_gap = cur_gap;
      if ((cur_len % CPB) == 6) begin
        cur_bits = {cur_bits[62:0], tx};
        cur_nbits++;
      end
      cur_len++;
    end else begin
      if (cur_len > 0) begin
        run_len.push_back(cur_len);
        run_gap.push_back(start_gap);
        run_nbits.push_back(cur_nbits);
        run_bits.push_back(cur_bits);
        cur_len   = 0;
        cur_gap   = 0;
        cur_nbits = 0;
        cur_bits  = '0;
      end
      cur_gap++;
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    if (!reset && tx_valid && tx_ready) hs_cnt++;
  end

  task automatic clear_runs();
    run_len.delete();
    run_gap.delete();
    run_nbits.delete();
    run_bits.delete();
  endtask

  task automatic wait_ready();
    for (int t = 0; t < 1000 && !tx_ready; t++) @(negedge clk);
    if (!tx_ready) check("ready_timeout", 64'(tx_ready), 64'(1));
  endtask

  // Called at a negedge; returns at the negedge just after the handshake edge.
  task automatic send_word(input logic [9:0] w);
    tx_valid = 1'b1;
    tx_data  = w;
    wait_ready();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int quiet;
    quiet = 0;
    for (int t = 0; t < 3000 && quiet < 4; t++) begin
      @(negedge clk);
      if (!tx_active && tx_ready) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) check("quiet_timeout", 64'(quiet), 64'(4));
  endtask

  initial begin
    logic [9:0] words[3];
    int         hs_before;
    words[0] = 10'h155;
    words[1] = 10'h0F0;
    words[2] = 10'h001;

    repeat (3) @(negedge clk);
    check("reset_tx", 64'(tx), 64'(0));
    check("reset_active", 64'(tx_active), 64'(0));
    check("reset_ready", 64'(tx_ready), 64'(1));
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of the data field.
    send_word(10'h1C3);
    repeat (90) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_tx", 64'(tx), 64'(0));
    check("abort_active", 64'(tx_active), 64'(0));
    check("abort_ready", 64'(tx_ready), 64'(1));
    @(negedge clk);
    reset = 1'b0;
    clear_runs();
    @(negedge clk);

    // Single word after the abort: full fresh frame.
    send_word(10'h2A5);
    repeat (56) @(negedge clk);
    check("ready_in_sync_first", 64'(tx_ready), 64'(0));
    @(negedge clk);
    check("ready_after_sync", 64'(tx_ready), 64'(1));
    wait_quiet();
    check("single_runs", 64'(run_len.size()), 64'(1));
    if (run_len.size() >= 1) begin
      check("single_len", 64'(run_len[0]), 64'(168));
      check("single_nbits", 64'(run_nbits[0]), 64'(21));
      check("single_bits", run_bits[0], 64'({7'b1111101, 1'b1, 10'h2A5, 1'b1, 2'b01}));
    end
    clear_runs();

    // Second word offered during DATA joins the same frame.
    send_word(10'h000);
    repeat (70) @(negedge clk);
    send_word(10'h3FF);
    wait_quiet();
    check("b2b_runs", 64'(run_len.size()), 64'(1));
    if (run_len.size() >= 1) begin
      check("b2b_len", 64'(run_len[0]), 64'(264));
      check("b2b_bits", run_bits[0],
            64'({7'b1111101, 1'b1, 10'h000, 1'b0, 1'b1, 10'h3FF, 1'b0, 2'b01}));
    end
    clear_runs();

    // Second word offered one clock after the parity end strobe: new frame.
    send_word(10'h0C3);
    repeat (152) @(negedge clk);
    send_word(10'h155);
    wait_quiet();
    check("late_runs", 64'(run_len.size()), 64'(2));
    if (run_len.size() >= 2) begin
      check("late_len0", 64'(run_len[0]), 64'(168));
      check("late_len1", 64'(run_len[1]), 64'(168));
      check("late_gap", 64'(run_gap[1]), 64'(1));
      check("late_bits1", run_bits[1], 64'({7'b1111101, 1'b1, 10'h155, 1'b1, 2'b01}));
    end
    clear_runs();

    // Valid held high across three words.
    hs_before = hs_cnt;
    tx_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tx_data = words[k];
      wait_ready();
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_quiet();
    check("stream_handshakes", 64'(hs_cnt - hs_before), 64'(3));
    check("stream_runs", 64'(run_len.size()), 64'(1));
    if (run_len.size() >= 1) begin
      check("stream_len", 64'(run_len[0]), 64'(360));
      check("stream_bits", run_bits[0],
            64'({7'b1111101, 1'b1, 10'h155, 1'b1, 1'b1, 10'h0F0, 1'b0, 1'b1, 10'h001, 1'b1,
                 2'b01}));
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
